// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for apb_master.
// master: the initiator view; slave: driver plus APB target view.
interface apb_master_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    localparam int STRB_WIDTH = BUS_WIDTH / DATA_WIDTH;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [BUS_WIDTH-1:0]  cmd_wdata_i;
    logic [STRB_WIDTH-1:0] cmd_strb_i;

    logic                  rsp_valid_o;
    logic [BUS_WIDTH-1:0]  rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;

    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [BUS_WIDTH-1:0]  pwdata_o;
    logic [STRB_WIDTH-1:0] pstrb_o;
    logic [BUS_WIDTH-1:0]  prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;

    logic                  busy_o;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i,
        input  cmd_wdata_i, cmd_strb_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_timeout_o,
        output psel_o, penable_o, pwrite_o, paddr_o,
        output pwdata_o, pstrb_o,
        input  prdata_i, pready_i, pslverr_i,
        output busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i,
        output cmd_wdata_i, cmd_strb_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_timeout_o,
        input  psel_o, penable_o, pwrite_o, paddr_o,
        input  pwdata_o, pstrb_o,
        output prdata_i, pready_i, pslverr_i,
        input  busy_o
    );
endinterface

// File: rtl/apb_master.sv
// APB3/APB4 initiator: single-beat command port to APB transfers,
// with wait-state timeout abort and one-cycle response pulse.
module apb_master #(
    parameter int BUS_WIDTH      = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic         clk_i,
    input logic         rst_ni,
    apb_master_if.master bus
);
    localparam int STRB_WIDTH = BUS_WIDTH / DATA_WIDTH;
    localparam int CNT_WIDTH  =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, next_state;

    logic                  ready;
    logic                  accept;
    logic                  done;
    logic                  expire;
    logic [CNT_WIDTH-1:0]  cnt;

    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [BUS_WIDTH-1:0]  pwdata_q;
    logic [STRB_WIDTH-1:0] pstrb_q;
    logic                  rsp_valid_q;
    logic [BUS_WIDTH-1:0]  rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;

    // An abort edge always has pready low, so ready is already 0 there.
    always_comb begin
        done   = (state == ACCESS) && bus.pready_i;
        expire = TIMEOUT_EN && (state == ACCESS) &&
                 !bus.pready_i && (cnt == CNT_LAST);
        ready  = (state == IDLE) || done;
        accept = bus.cmd_valid_i && ready;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (accept) next_state = SETUP;
            SETUP:  next_state = ACCESS;
            ACCESS: begin
                if (done)        next_state = accept ? SETUP : IDLE;
                else if (expire) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.psel_o        = (state != IDLE);
        bus.penable_o     = (state == ACCESS);
        bus.busy_o        = (state != IDLE);
        bus.cmd_ready_o   = ready;
        bus.pwrite_o      = pwrite_q;
        bus.paddr_o       = paddr_q;
        bus.pwdata_o      = pwdata_q;
        bus.pstrb_o       = pstrb_q;
        bus.rsp_valid_o   = rsp_valid_q;
        bus.rsp_rdata_o   = rsp_rdata_q;
        bus.rsp_err_o     = rsp_err_q;
        bus.rsp_timeout_o = rsp_timeout_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt           <= '0;
        end else begin
            if (accept) begin
                pwrite_q <= bus.cmd_write_i;
                paddr_q  <= bus.cmd_addr_i;
                pwdata_q <= bus.cmd_write_i ? bus.cmd_wdata_i : '0;
                pstrb_q  <= bus.cmd_write_i ? bus.cmd_strb_i : '0;
            end
            rsp_valid_q <= done || expire;
            // pwrite_q still describes the completing transfer here.
            if (done) begin
                rsp_err_q     <= bus.pslverr_i;
                rsp_timeout_q <= 1'b0;
                rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata_i;
            end else if (expire) begin
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
                rsp_rdata_q   <= '0;
            end
            if (state == SETUP)
                cnt <= '0;
            else if (state == ACCESS && !bus.pready_i)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, waited read, slave error,
// timeout abort, back-to-back writes and reset mid-transfer.
module tb_apb_master;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_if #(
        .BUS_WIDTH(32), .DATA_WIDTH(8), .ADDR_WIDTH(16)
    ) bus ();

    apb_master #(
        .BUS_WIDTH(32), .DATA_WIDTH(8),
        .ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (bus.psel_o !== 1'b0 || bus.penable_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus: psel=%b penable=%b want 0 0",
                     bus.psel_o, bus.penable_o);
        end
        n_checks++;
        if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: ready=%b busy=%b want 1 0",
                     bus.cmd_ready_o, bus.busy_o);
        end
        n_checks++;
        if (bus.rsp_valid_o !== 1'b0 || bus.paddr_o !== 16'h0 ||
            bus.rsp_rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: rv=%b paddr=%h rdata=%h want 0",
                     bus.rsp_valid_o, bus.paddr_o, bus.rsp_rdata_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_write();
        bus.pready_i    = 1'b1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = 16'h0010;
        bus.cmd_wdata_i = 32'h0000_00AB;
        bus.cmd_strb_i  = 4'b1111;
        tick();
        bus.cmd_valid_i = 1'b0;
        n_checks++;
        if (bus.psel_o !== 1'b1 || bus.penable_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_setup: psel=%b penable=%b want 1 0",
                     bus.psel_o, bus.penable_o);
        end
        n_checks++;
        if (bus.pwdata_o !== 32'h0000_00AB || bus.paddr_o !== 16'h0010 ||
            bus.pstrb_o !== 4'hF || bus.pwrite_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_bus: wd=%h a=%h s=%h w=%b want ab 0010 f 1",
                     bus.pwdata_o, bus.paddr_o, bus.pstrb_o, bus.pwrite_o);
        end
        tick();
        n_checks++;
        if (bus.psel_o !== 1'b1 || bus.penable_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_access: psel=%b penable=%b want 1 1",
                     bus.psel_o, bus.penable_o);
        end
        tick();
        n_checks++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0 ||
            bus.psel_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rsp: rv=%b err=%b psel=%b want 1 0 0",
                     bus.rsp_valid_o, bus.rsp_err_o, bus.psel_o);
        end
        tick();
        n_checks++;
        if (bus.rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_pulse: rv=%b want 0", bus.rsp_valid_o);
        end
    endtask

    task automatic test_read_wait();
        int acc = 0;
        bit bad = 1'b0;
        bus.pready_i    = 1'b0;
        bus.prdata_i    = 32'h0000_0BAD;
        bus.pslverr_i   = 1'b1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 16'h0020;
        bus.cmd_wdata_i = 32'h1234_5678;
        bus.cmd_strb_i  = 4'b1111;
        tick();
        bus.cmd_valid_i = 1'b0;
        n_checks++;
        if (bus.pwdata_o !== 32'h0 || bus.pstrb_o !== 4'h0 ||
            bus.pwrite_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_setup: wd=%h s=%h w=%b want 0 0 0",
                     bus.pwdata_o, bus.pstrb_o, bus.pwrite_o);
        end
        tick();
        for (int i = 0; i < 12 && bus.penable_o; i++) begin
            acc++;
            if (bus.paddr_o !== 16'h0020 || bus.pwrite_o !== 1'b0 ||
                bus.psel_o !== 1'b1 || bus.pstrb_o !== 4'h0)
                bad = 1'b1;
            if (acc == 4) begin
                bus.pready_i  = 1'b1;
                bus.prdata_i  = 32'hDEAD_BEEF;
                bus.pslverr_i = 1'b0;
            end
            tick();
        end
        n_checks++;
        if (acc !== 4) begin
            n_fail++;
            $display("FAIL rd_access_len: got %0d cycles want 4", acc);
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rd_stable: bus changed during wait got 1 want 0");
        end
        n_checks++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 32'hDEAD_BEEF ||
            bus.rsp_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_rsp: rv=%b rd=%h err=%b want 1 deadbeef 0",
                     bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_o);
        end
        tick();
    endtask

    task automatic test_timeout();
        int acc = 0;
        bit bad = 1'b0;
        bus.pready_i    = 1'b0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 16'h0040;
        tick();
        bus.cmd_addr_i = 16'h0044;
        tick();
        for (int i = 0; i < 40 && bus.psel_o; i++) begin
            if (bus.penable_o) acc++;
            if (bus.cmd_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b0)
                bad = 1'b1;
            tick();
        end
        n_checks++;
        if (acc !== 16) begin
            n_fail++;
            $display("FAIL to_len: got %0d access cycles want 16", acc);
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL to_ready: ready/rv high in wait got 1 want 0");
        end
        n_checks++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1 ||
            bus.rsp_timeout_o !== 1'b1 || bus.rsp_rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL to_rsp: rv=%b err=%b to=%b rd=%h want 1 1 1 0",
                     bus.rsp_valid_o, bus.rsp_err_o,
                     bus.rsp_timeout_o, bus.rsp_rdata_o);
        end
        n_checks++;
        if (bus.psel_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 ||
            bus.paddr_o !== 16'h0040) begin
            n_fail++;
            $display("FAIL to_idle: psel=%b rdy=%b a=%h want 0 1 0040",
                     bus.psel_o, bus.cmd_ready_o, bus.paddr_o);
        end
        bus.cmd_valid_i = 1'b0;
        tick();
        n_checks++;
        if (bus.rsp_valid_o !== 1'b0 || bus.psel_o !== 1'b0) begin
            n_fail++;
            $display("FAIL to_after: rv=%b psel=%b want 0 0",
                     bus.rsp_valid_o, bus.psel_o);
        end
    endtask

    task automatic test_slverr();
        bus.pready_i    = 1'b1;
        bus.pslverr_i   = 1'b1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = 16'h0030;
        bus.cmd_wdata_i = 32'h0000_0055;
        bus.cmd_strb_i  = 4'b0011;
        tick();
        bus.cmd_valid_i = 1'b0;
        n_checks++;
        if (bus.pstrb_o !== 4'b0011) begin
            n_fail++;
            $display("FAIL err_strb: got %b want 0011", bus.pstrb_o);
        end
        tick();
        tick();
        n_checks++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1 ||
            bus.rsp_timeout_o !== 1'b0 || bus.rsp_rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL err_rsp: rv=%b err=%b to=%b rd=%h want 1 1 0 0",
                     bus.rsp_valid_o, bus.rsp_err_o,
                     bus.rsp_timeout_o, bus.rsp_rdata_o);
        end
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.psel_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_idle: busy=%b psel=%b want 0 0",
                     bus.busy_o, bus.psel_o);
        end
        bus.pslverr_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ps = '0;
        logic [6:0]  pe = '0;
        logic [6:0]  rv = '0;
        logic [15:0] a0 = '0;
        logic [15:0] a1 = '0;
        logic [15:0] a2 = '0;
        logic [31:0] d2 = '0;
        bus.pready_i    = 1'b1;
        bus.pslverr_i   = 1'b0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b1;
        bus.cmd_strb_i  = 4'b1111;
        bus.cmd_addr_i  = 16'h0100;
        bus.cmd_wdata_i = 32'h1;
        for (int i = 0; i < 7; i++) begin
            tick();
            ps[i] = bus.psel_o;
            pe[i] = bus.penable_o;
            rv[i] = bus.rsp_valid_o;
            if (i == 0) begin
                a0 = bus.paddr_o;
                bus.cmd_addr_i  = 16'h0104;
                bus.cmd_wdata_i = 32'h2;
            end
            if (i == 2) begin
                a1 = bus.paddr_o;
                bus.cmd_addr_i  = 16'h0108;
                bus.cmd_wdata_i = 32'h3;
            end
            if (i == 4) begin
                a2 = bus.paddr_o;
                d2 = bus.pwdata_o;
                bus.cmd_valid_i = 1'b0;
            end
        end
        n_checks++;
        if (ps !== 7'b0111111) begin
            n_fail++;
            $display("FAIL b2b_psel: got %b want 0111111", ps);
        end
        n_checks++;
        if (pe !== 7'b0101010) begin
            n_fail++;
            $display("FAIL b2b_penable: got %b want 0101010", pe);
        end
        n_checks++;
        if (rv !== 7'b1010100) begin
            n_fail++;
            $display("FAIL b2b_rsp: got %b want 1010100", rv);
        end
        n_checks++;
        if (a0 !== 16'h0100 || a1 !== 16'h0104 ||
            a2 !== 16'h0108 || d2 !== 32'h3) begin
            n_fail++;
            $display("FAIL b2b_addr: got %h %h %h d=%h want 0100 0104 0108 3",
                     a0, a1, a2, d2);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        bus.pready_i    = 1'b0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 16'h0050;
        tick();
        bus.cmd_valid_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.penable_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: penable=%b want 1", bus.penable_o);
        end
        #3 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (bus.psel_o !== 1'b0 || bus.penable_o !== 1'b0 ||
            bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: psel=%b pen=%b busy=%b want 0 0 0",
                     bus.psel_o, bus.penable_o, bus.busy_o);
        end
        bus.pready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.rsp_valid_o !== 1'b0) bad = 1'b1;
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        if (bus.rsp_valid_o !== 1'b0) bad = 1'b1;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_norsp: rsp_valid seen got 1 want 0");
        end
        bus.prdata_i    = 32'h0BAD_F00D;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 16'h0060;
        tick();
        bus.cmd_valid_i = 1'b0;
        n_checks++;
        if (bus.psel_o !== 1'b1 || bus.paddr_o !== 16'h0060) begin
            n_fail++;
            $display("FAIL rst_new_setup: psel=%b a=%h want 1 0060",
                     bus.psel_o, bus.paddr_o);
        end
        tick();
        tick();
        n_checks++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 32'h0BAD_F00D ||
            bus.rsp_err_o !== 1'b0 || bus.rsp_timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_new_rsp: rv=%b rd=%h err=%b to=%b",
                     bus.rsp_valid_o, bus.rsp_rdata_o,
                     bus.rsp_err_o, bus.rsp_timeout_o);
        end
        tick();
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.cmd_strb_i  = '0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b1;
        bus.pslverr_i   = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
